clk_period_meter: RTL and testbench

- Receive-side counterpart to the board's clock dividers: takes a slow square wave (divider SCLK output, or an external slow clock/strobe line) into the CLK domain and measures its half-period in CLK cycles.
- Used for self-check of divider settings, and for recovering tick rate from slow external signals.
- Also provides a per-edge strobe and a loss-of-signal flag.

---
 rtl/clk_period_meter.sv | 122 ++++++++++++
 tb/tb_clk_period_meter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the edge-to-edge spacing of a slow asynchronous square wave in CLK cycles,
// with a per-edge strobe, a lock-valid flag and a sticky loss-of-signal flag.
module clk_period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 4400
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SCLK_IN,
    input  logic             CLR,
    output logic             EDGE_STB,
    output logic             UPD,
    output logic [CNT_W-1:0] HALF_PERIOD,
    output logic             VALID,
    output logic             LOST
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic             sync1_q, sync2_q, prev_q;
    logic             edge_q;
    logic             stb_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             upd_q, upd_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;

    // edge_q is the internal edge event; every output is registered one cycle later,
    // so EDGE_STB, UPD and the HALF_PERIOD load all become visible on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            upd_q   <= 1'b0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            sync1_q <= SCLK_IN;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q ^ prev_q;
            stb_q   <= edge_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            upd_q   <= upd_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
        end
    end

    // The counter reads 0 while EDGE_STB is high, so count+1 at the closing edge
    // equals the number of cycles between strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        upd_d   = 1'b0;
        valid_d = valid_q;
        lost_d  = lost_q;
        if (CLR) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            half_d  = '0;
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (edge_q) state_d = ST_ARMED;
                end
                ST_ARMED, ST_LOCKED: begin
                    if (edge_q) begin
                        half_d  = cnt_q + CNT_ONE;
                        upd_d   = 1'b1;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_LOCKED;
                    end else if (cnt_q == CNT_MAX) begin
                        lost_d  = 1'b1;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign EDGE_STB    = stb_q;
    assign UPD         = upd_q;
    assign HALF_PERIOD = half_q;
    assign VALID       = valid_q;
    assign LOST        = lost_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: two instances (default TIMEOUT and TIMEOUT=8),
// expected HALF_PERIOD values queued at stimulus time and popped on each UPD.
module tb_clk_period_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        sclk_a = 1'b0;
    logic        sclk_b = 1'b0;

    logic        stb_a, upd_a, valid_a, lost_a;
    logic [31:0] half_a;
    logic        stb_b, upd_b, valid_b, lost_b;
    logic [31:0] half_b;

    int total = 0;
    int bad = 0;
    int expq_a[$];
    int expq_b[$];
    int ea, eb;
    int upd_cnt_a = 0;
    int base_a;

    always #5 clk = ~clk;

    clk_period_meter #(.CNT_W(32), .TIMEOUT(4400)) dut_a (
        .CLK(clk), .RST_N(rst_n), .SCLK_IN(sclk_a), .CLR(clr),
        .EDGE_STB(stb_a), .UPD(upd_a), .HALF_PERIOD(half_a), .VALID(valid_a), .LOST(lost_a)
    );

    clk_period_meter #(.CNT_W(32), .TIMEOUT(8)) dut_b (
        .CLK(clk), .RST_N(rst_n), .SCLK_IN(sclk_b), .CLR(1'b0),
        .EDGE_STB(stb_b), .UPD(upd_b), .HALF_PERIOD(half_b), .VALID(valid_b), .LOST(lost_b)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tog_a(input int gap, input int exp);
        tick(gap);
        sclk_a = ~sclk_a;
        if (exp > 0) expq_a.push_back(exp);
    endtask

    task automatic tog_b(input int gap, input int exp);
        tick(gap);
        sclk_b = ~sclk_b;
        if (exp > 0) expq_b.push_back(exp);
    endtask

    always @(negedge clk) begin
        if (upd_a) begin
            upd_cnt_a++;
            if (expq_a.size() == 0) begin
                chk1("upd_a_unexpected", upd_a, 1'b0);
            end else begin
                ea = expq_a.pop_front();
                chkn("half_a", half_a, ea);
                chk1("valid_a_at_upd", valid_a, 1'b1);
                chk1("stb_a_at_upd", stb_a, 1'b1);
            end
        end
    end

    always @(negedge clk) begin
        if (upd_b) begin
            if (expq_b.size() == 0) begin
                chk1("upd_b_unexpected", upd_b, 1'b0);
            end else begin
                eb = expq_b.pop_front();
                chkn("half_b", half_b, eb);
                chk1("stb_b_at_upd", stb_b, 1'b1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        chk1("rst_stb", stb_a, 1'b0);
        chk1("rst_upd", upd_a, 1'b0);
        chkn("rst_half", half_a, 32'd0);
        chk1("rst_valid", valid_a, 1'b0);
        chk1("rst_lost", lost_a, 1'b0);
        rst_n = 1'b1;

        // Small TIMEOUT: spacing of exactly TIMEOUT locks, TIMEOUT+1 is lost
        tog_b(3, 0);
        repeat (4) tog_b(8, 8);
        chk1("b_lost_at_8", lost_b, 1'b0);
        chk1("b_valid_at_8", valid_b, 1'b1);
        tog_b(9, 0);
        tick(2);
        chk1("b_lost_pre", lost_b, 1'b0);
        tick(1);
        chk1("b_lost_at_9", lost_b, 1'b1);
        chk1("b_valid_at_9", valid_b, 1'b0);
        chkn("b_half_held", half_b, 32'd8);

        // Lock at 1100; strobe latency for both polarities
        tog_a(5, 0);
        tick(3);
        chk1("lat_rise_early", stb_a, 1'b0);
        tick(1);
        chk1("lat_rise", stb_a, 1'b1);
        chk1("first_edge_no_upd", upd_a, 1'b0);
        chk1("first_edge_no_valid", valid_a, 1'b0);
        tog_a(1096, 1100);
        tick(3);
        chk1("lat_fall_early", stb_a, 1'b0);
        tick(1);
        chk1("lat_fall", stb_a, 1'b1);
        chk1("second_edge_upd", upd_a, 1'b1);
        chk1("second_edge_valid", valid_a, 1'b1);
        tog_a(1096, 1100);
        tog_a(1100, 1100);
        chk1("lock_lost", lost_a, 1'b0);

        // Loss of signal exactly TIMEOUT cycles after the last strobe
        tick(4403);
        chk1("timeout_early", lost_a, 1'b0);
        chk1("timeout_early_valid", valid_a, 1'b1);
        tick(1);
        chk1("timeout_lost", lost_a, 1'b1);
        chk1("timeout_valid", valid_a, 1'b0);
        chkn("timeout_half_held", half_a, 32'd1100);

        // Re-lock keeps LOST; CLR releases it
        tog_a(50, 0);
        tog_a(1100, 1100);
        tick(4);
        chk1("relock_valid", valid_a, 1'b1);
        chk1("relock_lost_sticky", lost_a, 1'b1);
        tick(20);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk1("clr_lost", lost_a, 1'b0);
        chk1("clr_valid", valid_a, 1'b0);
        chkn("clr_half", half_a, 32'd0);

        // Minimum spacing 2, then 5: one UPD per edge
        base_a = upd_cnt_a;
        tog_a(10, 0);
        repeat (4) tog_a(2, 2);
        repeat (3) tog_a(5, 5);
        tick(10);
        chkn("upd_per_edge", upd_cnt_a - base_a, 32'd7);
        chkn("fast_half_last", half_a, 32'd5);

        // CLR sampled on the same edge that raises EDGE_STB
        tog_a(20, 0);
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk1("clr_edge_stb", stb_a, 1'b1);
        chk1("clr_edge_upd", upd_a, 1'b0);
        chk1("clr_edge_valid", valid_a, 1'b0);
        chkn("clr_edge_half", half_a, 32'd0);
        tog_a(3, 0);
        tog_a(7, 7);
        tick(4);
        chk1("after_clr_valid", valid_a, 1'b1);
        chkn("after_clr_half", half_a, 32'd7);

        // Asynchronous reset mid-interval; SCLK_IN is high at release
        tick(100);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_stb", stb_a, 1'b0);
        chk1("arst_upd", upd_a, 1'b0);
        chkn("arst_half", half_a, 32'd0);
        chk1("arst_valid", valid_a, 1'b0);
        chk1("arst_lost", lost_a, 1'b0);
        chk1("arst_lost_b", lost_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        chk1("rel_high_early", stb_a, 1'b0);
        tick(1);
        chk1("rel_high_edge", stb_a, 1'b1);
        chk1("rel_high_no_upd", upd_a, 1'b0);
        chk1("rel_high_no_valid", valid_a, 1'b0);
        tog_a(6, 10);
        tick(4);
        chk1("rel_upd", upd_a, 1'b1);
        chk1("rel_valid", valid_a, 1'b1);

        tick(10);
        chkn("queue_a_drained", expq_a.size(), 32'd0);
        chkn("queue_b_drained", expq_b.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
